// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational RV32I ALU between two requesters.
// One operation in flight: accept (IDLE) -> drive ALU (EXEC) -> hold result (RESP).

// Per-port handshake glue: gates the shared grant/response onto one requester.
module alu_share_port #(
    parameter int XLEN = 32
) (
    input  logic            grant,
    input  logic            sel,
    input  logic            req_valid,
    input  logic [XLEN-1:0] res_q,
    input  logic            zero_q,
    output logic            req_ready,
    output logic            rsp_valid,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    assign req_ready = grant & req_valid;
    assign rsp_valid = sel;
    // Payload is forced to 0 on the port that does not own the response.
    assign result    = sel ? res_q : '0;
    assign zero      = sel & zero_q;
endmodule

module alu_share_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            p0_req_valid,
    output logic            p0_req_ready,
    input  logic [OPW-1:0]  p0_op,
    input  logic [XLEN-1:0] p0_a,
    input  logic [XLEN-1:0] p0_b,
    output logic            p0_rsp_valid,
    input  logic            p0_rsp_ready,
    output logic [XLEN-1:0] p0_result,
    output logic            p0_zero,

    input  logic            p1_req_valid,
    output logic            p1_req_ready,
    input  logic [OPW-1:0]  p1_op,
    input  logic [XLEN-1:0] p1_a,
    input  logic [XLEN-1:0] p1_b,
    output logic            p1_rsp_valid,
    input  logic            p1_rsp_ready,
    output logic [XLEN-1:0] p1_result,
    output logic            p1_zero,

    output logic [OPW-1:0]  alu_op,
    output logic [XLEN-1:0] alu_data1,
    output logic [XLEN-1:0] alu_data2,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero
);
    localparam int NUM_PORTS = 2;

    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } alu_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t   state, state_nxt;
    alu_req_t req_q;
    alu_req_t [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] req_valid, req_ready, rsp_ready, rsp_valid, rsp_zero;
    logic [NUM_PORTS-1:0][XLEN-1:0] rsp_result;
    logic [NUM_PORTS-1:0] grant_vec, sel_vec;
    logic [XLEN-1:0] res_q;
    logic            zero_q;
    logic            gnt_q, last_grant, gnt_sel, any_req, accept;

    assign req[0]    = {p0_op, p0_a, p0_b};
    assign req[1]    = {p1_op, p1_a, p1_b};
    assign req_valid = {p1_req_valid, p0_req_valid};
    assign rsp_ready = {p1_rsp_ready, p0_rsp_ready};

    // Contention goes to the port that did not win last time.
    assign any_req = |req_valid;
    assign gnt_sel = (&req_valid) ? ~last_grant : req_valid[1];
    assign accept  = (state == IDLE) && any_req;

    assign grant_vec = accept ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
    assign sel_vec   = (state == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready[gnt_q]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_q      <= '0;
            gnt_q      <= 1'b0;
            last_grant <= 1'b1;
            res_q      <= '0;
            zero_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q      <= req[gnt_sel];
                gnt_q      <= gnt_sel;
                last_grant <= gnt_sel;
            end
            if (state == EXEC) begin
                res_q  <= alu_result;
                zero_q <= alu_zero;
            end
        end
    end

    // ALU inputs come straight from the operand registers so they only move on accept.
    assign alu_op    = req_q.op;
    assign alu_data1 = req_q.a;
    assign alu_data2 = req_q.b;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        alu_share_port #(.XLEN(XLEN)) u_port (
            .grant     (grant_vec[i]),
            .sel       (sel_vec[i]),
            .req_valid (req_valid[i]),
            .res_q     (res_q),
            .zero_q    (zero_q),
            .req_ready (req_ready[i]),
            .rsp_valid (rsp_valid[i]),
            .result    (rsp_result[i]),
            .zero      (rsp_zero[i])
        );
    end

    assign p0_req_ready = req_ready[0];
    assign p1_req_ready = req_ready[1];
    assign p0_rsp_valid = rsp_valid[0];
    assign p1_rsp_valid = rsp_valid[1];
    assign p0_result    = rsp_result[0];
    assign p1_result    = rsp_result[1];
    assign p0_zero      = rsp_zero[0];
    assign p1_zero      = rsp_zero[1];

    a_one_ready: assert property (@(posedge clk) !(p0_req_ready && p1_req_ready));
endmodule
